// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler configuration path: FSM state encoding and
// the step-divider width (16-bit size plus log2 of the fixed-point unit step).
package scaler_pkg;

    localparam int unsigned SIZE_W             = 16;
    localparam int unsigned SCALE_STEP_DEFAULT = 4096;

    function automatic int unsigned div_width(input int unsigned step);
        return SIZE_W + $clog2(step);
    endfunction

    localparam int unsigned DW = div_width(SCALE_STEP_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        DIV_H,
        DIV_V,
        PEND
    } cfg_state_e;

endpackage

// File: rtl/scaler_step_div.sv
// Restoring divider, one quotient bit per cycle; result saturates to 16 bits.
// done_o is high in the WIDTH-th cycle after start_i; start_i always restarts, no backpressure.
module scaler_step_div
    import scaler_pkg::*;
#(
    parameter int unsigned WIDTH = DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  num_i,
    input  logic [SIZE_W-1:0] den_i,
    output logic              done_o,
    output logic [SIZE_W-1:0] quo_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  num_q;
    logic [WIDTH-1:0]  quo_q;
    logic [SIZE_W-1:0] den_q;
    logic [SIZE_W:0]   rem_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;

    logic [SIZE_W+1:0] rem_shift;
    logic [SIZE_W+1:0] rem_sub;
    logic              bit_ge;
    logic [WIDTH-1:0]  quo_full;

    // quo_full already contains the bit being resolved this cycle, so the
    // caller can take the result in the same cycle done_o is high.
    always_comb begin
        rem_shift = {rem_q, num_q[WIDTH-1]};
        rem_sub   = rem_shift - {2'b00, den_q};
        bit_ge    = rem_shift >= {2'b00, den_q};
        quo_full  = WIDTH'({quo_q, bit_ge});
    end

    assign done_o = busy_q && (cnt_q == CW'(1));
    assign quo_o  = (quo_full > WIDTH'(16'hFFFF)) ? 16'hFFFF : quo_full[SIZE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            num_q  <= num_i;
            den_q  <= den_i;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            num_q  <= num_q << 1;
            rem_q  <= (SIZE_W + 1)'(bit_ge ? rem_sub : rem_shift);
            quo_q  <= quo_full;
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= (cnt_q != CW'(1));
        end
    end

endmodule

// File: rtl/scaler_cfg_ctrl.sv
// Turns requested in/out sizes into fixed-point scale steps and commits them on vsync rise.
// cfg_wr reaches commit-ready after 2*DW+1 cycles; cfg_wr is dropped while cfg_busy is high.
module scaler_cfg_ctrl
    import scaler_pkg::*;
#(
    parameter int unsigned SCALE_STEP           = 4096,
    parameter int unsigned LINE_IN_SIZE_DEFAULT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_h_in_size,
    input  logic [15:0] cfg_h_out_size,
    input  logic [15:0] cfg_v_in_size,
    input  logic [15:0] cfg_v_out_size,
    input  logic        cfg_wr,
    input  logic        vs_i,
    output logic [15:0] reg_h_scale_step,
    output logic [15:0] reg_v_scale_step,
    output logic [15:0] reg_v_scale_inline_size,
    output logic        cfg_busy,
    output logic        cfg_err,
    output logic        cfg_applied
);

    localparam int unsigned STEP_LOG2 = $clog2(SCALE_STEP);
    localparam int unsigned CDW       = div_width(SCALE_STEP);

    cfg_state_e  state_q, state_d;
    logic        start_q, start_d;
    logic [15:0] h_in_q, h_in_d, h_out_q, h_out_d;
    logic [15:0] v_in_q, v_in_d, v_out_q, v_out_d;
    logic [15:0] h_sh_q, h_sh_d, v_sh_q, v_sh_d;
    logic [15:0] reg_h_q, reg_h_d, reg_v_q, reg_v_d, reg_inl_q, reg_inl_d;
    logic        busy_q, busy_d, err_q, err_d, applied_q, applied_d;
    logic        vs_prev_q;
    logic        vs_edge;

    logic            div_start;
    logic [CDW-1:0]  div_num;
    logic [15:0]     div_den;
    logic            div_done;
    logic [15:0]     div_quo;

    assign vs_edge = vs_i & ~vs_prev_q;

    scaler_step_div #(
        .WIDTH (CDW)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   (div_num),
        .den_i   (div_den),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        h_in_d    = h_in_q;
        h_out_d   = h_out_q;
        v_in_d    = v_in_q;
        v_out_d   = v_out_q;
        h_sh_d    = h_sh_q;
        v_sh_d    = v_sh_q;
        reg_h_d   = reg_h_q;
        reg_v_d   = reg_v_q;
        reg_inl_d = reg_inl_q;
        busy_d    = busy_q;
        err_d     = err_q;
        applied_d = 1'b0;
        div_start = 1'b0;
        div_num   = '0;
        div_den   = '0;

        case (state_q)
            IDLE: begin
                if (cfg_wr) begin
                    h_in_d  = cfg_h_in_size;
                    h_out_d = cfg_h_out_size;
                    v_in_d  = cfg_v_in_size;
                    v_out_d = cfg_v_out_size;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = DIV_H;
                end
            end
            DIV_H: begin
                // First DIV_H cycle validates the latched sizes before any division.
                if (start_q) begin
                    if (h_in_q == '0 || h_out_q == '0 || v_in_q == '0 || v_out_q == '0) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        div_start = 1'b1;
                        div_num   = CDW'(h_in_q) << STEP_LOG2;
                        div_den   = h_out_q;
                    end
                end else if (div_done) begin
                    h_sh_d    = div_quo;
                    div_start = 1'b1;
                    div_num   = CDW'(v_in_q) << STEP_LOG2;
                    div_den   = v_out_q;
                    state_d   = DIV_V;
                end
            end
            DIV_V: begin
                if (div_done) begin
                    v_sh_d  = div_quo;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (vs_edge) begin
                    reg_h_d   = h_sh_q;
                    reg_v_d   = v_sh_q;
                    reg_inl_d = h_out_q;
                    applied_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            h_in_q    <= '0;
            h_out_q   <= '0;
            v_in_q    <= '0;
            v_out_q   <= '0;
            h_sh_q    <= '0;
            v_sh_q    <= '0;
            reg_h_q   <= 16'(SCALE_STEP);
            reg_v_q   <= 16'(SCALE_STEP);
            reg_inl_q <= 16'(LINE_IN_SIZE_DEFAULT);
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            applied_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            h_in_q    <= h_in_d;
            h_out_q   <= h_out_d;
            v_in_q    <= v_in_d;
            v_out_q   <= v_out_d;
            h_sh_q    <= h_sh_d;
            v_sh_q    <= v_sh_d;
            reg_h_q   <= reg_h_d;
            reg_v_q   <= reg_v_d;
            reg_inl_q <= reg_inl_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            applied_q <= applied_d;
            vs_prev_q <= vs_i;
        end
    end

    assign reg_h_scale_step        = reg_h_q;
    assign reg_v_scale_step        = reg_v_q;
    assign reg_v_scale_inline_size = reg_inl_q;
    assign cfg_busy                = busy_q;
    assign cfg_err                 = err_q;
    assign cfg_applied             = applied_q;

endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// Bench for scaler_cfg_ctrl: directed vector table, randomized transactions against
// a cycle-level expectation model, and reset-abort sequences.
module tb_scaler_cfg_ctrl;

    localparam int STEP  = 4096;
    localparam int DWT   = 16 + $clog2(STEP);
    localparam int LIMIT = 2 * DWT + 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_h_in_size, cfg_h_out_size, cfg_v_in_size, cfg_v_out_size;
    logic        cfg_wr, vs_i;
    logic [15:0] reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size;
    logic        cfg_busy, cfg_err, cfg_applied;

    always #5 clk = ~clk;

    scaler_cfg_ctrl #(
        .SCALE_STEP           (STEP),
        .LINE_IN_SIZE_DEFAULT (1024)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_h_in_size           (cfg_h_in_size),
        .cfg_h_out_size          (cfg_h_out_size),
        .cfg_v_in_size           (cfg_v_in_size),
        .cfg_v_out_size          (cfg_v_out_size),
        .cfg_wr                  (cfg_wr),
        .vs_i                    (vs_i),
        .reg_h_scale_step        (reg_h_scale_step),
        .reg_v_scale_step        (reg_v_scale_step),
        .reg_v_scale_inline_size (reg_v_scale_inline_size),
        .cfg_busy                (cfg_busy),
        .cfg_err                 (cfg_err),
        .cfg_applied             (cfg_applied)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] cur_h, cur_v, cur_i;

    typedef struct {
        logic [15:0] hi, ho, vi, vo;
        logic [15:0] eh, ev, ei;
        int          m1, m2;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic chk_all(input logic busy, input logic err, input logic app,
                           input logic [15:0] h, input logic [15:0] v, input logic [15:0] i);
        chk("cfg_busy", 32'(cfg_busy), 32'(busy));
        chk("cfg_err", 32'(cfg_err), 32'(err));
        chk("cfg_applied", 32'(cfg_applied), 32'(app));
        chk("reg_h_scale_step", 32'(reg_h_scale_step), 32'(h));
        chk("reg_v_scale_step", 32'(reg_v_scale_step), 32'(v));
        chk("reg_v_scale_inline_size", 32'(reg_v_scale_inline_size), 32'(i));
    endtask

    function automatic logic [15:0] calc_step(input logic [15:0] in_sz, input logic [15:0] out_sz);
        longint q;
        q = (longint'(in_sz) * STEP) / longint'(out_sz);
        return (q > 65535) ? 16'hFFFF : q[15:0];
    endfunction

    function automatic logic [15:0] rand_size();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return 16'd0;
        if (r < 4)  return 16'd1;
        if (r < 7)  return 16'hFFFF;
        return 16'($urandom_range(1, 4096));
    endfunction

    // Commit becomes possible 2*DWT+1 edges after acceptance, so the first vsync
    // rise sampled at edge T+k with k >= 2*DWT+2 is the one that applies.
    task automatic run_txn(input logic [15:0] hi, input logic [15:0] ho,
                           input logic [15:0] vi, input logic [15:0] vo,
                           input logic [15:0] eh, input logic [15:0] ev, input logic [15:0] ei,
                           input bit rnd, input int m1, input int m2);
        bit zero, v, pv, cb;
        int ck;
        zero = (hi == 0) || (ho == 0) || (vi == 0) || (vo == 0);
        ck   = -1;
        v    = rnd ? bit'($urandom_range(0, 1)) : 1'b0;
        cfg_h_in_size  = hi;
        cfg_h_out_size = ho;
        cfg_v_in_size  = vi;
        cfg_v_out_size = vo;
        cfg_wr = 1'b1;
        vs_i   = v;
        pv     = v;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            cb = (ck >= 0) && (k - 1 >= ck);
            if (zero)
                chk_all(k == 1, k >= 2, 1'b0, cur_h, cur_v, cur_i);
            else
                chk_all(!cb, 1'b0, (ck >= 0) && (k - 1 == ck),
                        cb ? eh : cur_h, cb ? ev : cur_v, cb ? ei : cur_i);
            if ((ck >= 0 && k - 1 > ck) || (zero && k >= 6)) break;
            cfg_wr         = 1'b0;
            cfg_h_in_size  = 16'($urandom);
            cfg_h_out_size = 16'($urandom);
            cfg_v_in_size  = 16'($urandom);
            cfg_v_out_size = 16'($urandom);
            if (!zero && ck < 0)
                cfg_wr = rnd ? ($urandom_range(0, 7) == 0) : (k == DWT + 5);
            if (rnd)
                v = (k >= 2 * DWT + 13) ? 1'b1 :
                    (k == 2 * DWT + 12) ? 1'b0 :
                    ($urandom_range(0, 5) == 0) ? !pv : pv;
            else
                v = (k == m1) || (k >= m2);
            vs_i = v;
            if (!zero && ck < 0 && k >= 2 * DWT + 2 && v && !pv) ck = k;
            pv = v;
        end
        cfg_wr = 1'b0;
        if (!zero) begin
            cur_h = eh;
            cur_v = ev;
            cur_i = ei;
        end
    endtask

    task automatic rst_mid(input int at_k);
        cfg_h_in_size  = 16'd1024;
        cfg_h_out_size = 16'd512;
        cfg_v_in_size  = 16'd768;
        cfg_v_out_size = 16'd384;
        cfg_wr = 1'b1;
        vs_i   = 1'b0;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
        end
        chk("busy_before_rst", 32'(cfg_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all(1'b0, 1'b0, 1'b0, 16'd4096, 16'd4096, 16'd1024);
        for (int k = 0; k < 2 * DWT + 8; k++) begin
            vs_i = (k % 4 == 1);
            @(negedge clk);
            chk_all(1'b0, 1'b0, 1'b0, 16'd4096, 16'd4096, 16'd1024);
        end
        vs_i  = 1'b0;
        cur_h = 16'd4096;
        cur_v = 16'd4096;
        cur_i = 16'd1024;
    endtask

    initial begin
        logic [15:0] hi, ho, vi, vo, eh, ev;
        rst = 1'b1;
        cfg_wr = 1'b0;
        vs_i   = 1'b0;
        cfg_h_in_size  = '0;
        cfg_h_out_size = '0;
        cfg_v_in_size  = '0;
        cfg_v_out_size = '0;
        cur_h = 16'd4096;
        cur_v = 16'd4096;
        cur_i = 16'd1024;

        vecs[0] = '{hi: 1024,  ho: 512,   vi: 768,   vo: 384,  eh: 8192,  ev: 8192,  ei: 512,   m1: 5,           m2: 2 * DWT + 2};
        vecs[1] = '{hi: 640,   ho: 1280,  vi: 480,   vo: 960,  eh: 2048,  ev: 2048,  ei: 1280,  m1: 2 * DWT + 1, m2: 2 * DWT + 3};
        vecs[2] = '{hi: 1024,  ho: 0,     vi: 768,   vo: 384,  eh: 2048,  ev: 2048,  ei: 1280,  m1: 1,           m2: 3};
        vecs[3] = '{hi: 65535, ho: 1,     vi: 100,   vo: 100,  eh: 65535, ev: 4096,  ei: 1,     m1: 10,          m2: 2 * DWT + 2};
        vecs[4] = '{hi: 1,     ho: 65535, vi: 1,     vo: 1,    eh: 0,     ev: 4096,  ei: 65535, m1: 40,          m2: 2 * DWT + 5};
        vecs[5] = '{hi: 65535, ho: 65535, vi: 1920,  vo: 1080, eh: 4096,  ev: 7281,  ei: 65535, m1: 2 * DWT,     m2: 2 * DWT + 2};
        vecs[6] = '{hi: 100,   ho: 100,   vi: 100,   vo: 0,    eh: 4096,  ev: 7281,  ei: 65535, m1: 1,           m2: 3};
        vecs[7] = '{hi: 1,     ho: 1,     vi: 65535, vo: 2,    eh: 4096,  ev: 65535, ei: 1,     m1: 3,           m2: 2 * DWT + 4};

        repeat (3) @(negedge clk);
        chk_all(1'b0, 1'b0, 1'b0, 16'd4096, 16'd4096, 16'd1024);
        rst = 1'b0;
        @(negedge clk);
        chk_all(1'b0, 1'b0, 1'b0, 16'd4096, 16'd4096, 16'd1024);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].hi, vecs[i].ho, vecs[i].vi, vecs[i].vo,
                    vecs[i].eh, vecs[i].ev, vecs[i].ei, 1'b0, vecs[i].m1, vecs[i].m2);

        for (int t = 0; t < 25; t++) begin
            hi = rand_size();
            ho = rand_size();
            vi = rand_size();
            vo = rand_size();
            eh = cur_h;
            ev = cur_v;
            if (hi != 0 && ho != 0 && vi != 0 && vo != 0) begin
                eh = calc_step(hi, ho);
                ev = calc_step(vi, vo);
            end
            run_txn(hi, ho, vi, vo, eh, ev, ho, 1'b1, 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        rst_mid(DWT + 8);
        rst_mid(2 * DWT + 4);

        run_txn(16'd1024, 16'd512, 16'd768, 16'd384, 16'd8192, 16'd8192, 16'd512,
                1'b0, 2 * DWT + 1, 2 * DWT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

endmodule
